// File: rtl/scr1_ahb_imem_slave_if.sv
// AHB-Lite bus bundle between the instruction-fetch master and the imem slave.
interface scr1_ahb_imem_slave_if #(
    parameter int SCR1_AHB_WIDTH = 32
);
    logic                      hsel;
    logic [1:0]                htrans;
    logic [SCR1_AHB_WIDTH-1:0] haddr;
    logic                      hwrite;
    logic [2:0]                hsize;
    logic [2:0]                hburst;
    logic [3:0]                hprot;
    logic                      hmastlock;
    logic                      hready;
    logic                      hreadyout;
    logic                      hresp;
    logic [SCR1_AHB_WIDTH-1:0] hrdata;

    modport master (
        output hsel, htrans, haddr, hwrite, hsize, hburst, hprot, hmastlock, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, htrans, haddr, hwrite, hsize, hburst, hprot, hmastlock, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/scr1_ahb_imem_slave.sv
// Instruction memory AHB-Lite slave: single-word reads with fixed wait states,
// two-cycle ERROR for anything else, plus a side loader port for preloading.
module scr1_ahb_imem_slave #(
    parameter int                          SCR1_AHB_WIDTH = 32,
    parameter int                          MEM_WORDS      = 1024,
    parameter logic [SCR1_AHB_WIDTH-1:0]   BASE_ADDR      = '0,
    parameter int                          WAIT_STATES    = 1,
    localparam int                         IDX_W          = $clog2(MEM_WORDS)
) (
    input  logic                      clk,
    input  logic                      rst,
    scr1_ahb_imem_slave_if.slave      ahb,
    input  logic                      ld_we,
    input  logic [IDX_W-1:0]          ld_addr,
    input  logic [SCR1_AHB_WIDTH-1:0] ld_wdata
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    localparam logic [2:0] WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    logic [2:0]                state_q, state_d;
    logic [2:0]                wait_cnt_q, wait_cnt_d;
    logic [SCR1_AHB_WIDTH-1:0] rdata_q;
    logic [SCR1_AHB_WIDTH-1:0] mem_q [MEM_WORDS];

    logic             accept;
    logic             can_accept;
    logic             in_range;
    logic             valid_acc;
    logic             start_read;
    logic [IDX_W-1:0] fetch_idx;
    logic             unused_ok;

    assign accept     = ahb.hsel & ahb.hready & ahb.htrans[1];
    assign can_accept = (state_q == ST_IDLE) | (state_q == ST_DATA) | (state_q == ST_ERR2);
    // BASE_ADDR is aligned to the memory size, so range is a compare of the upper bits
    assign in_range   = (ahb.haddr[SCR1_AHB_WIDTH-1:IDX_W+2] == BASE_ADDR[SCR1_AHB_WIDTH-1:IDX_W+2]);
    assign valid_acc  = !ahb.hwrite & (ahb.hsize == 3'b010) & (ahb.haddr[1:0] == 2'b00) & in_range;
    assign start_read = can_accept & accept & valid_acc;
    assign fetch_idx  = ahb.haddr[IDX_W+1:2];
    assign unused_ok  = ^{ahb.hburst, ahb.hprot, ahb.hmastlock};

    // Next-state and wait-counter decode; completion cycles may launch the next transfer
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept) begin
                    if (valid_acc) begin
                        if (WAIT_STATES > 0) begin
                            state_d    = ST_WAIT;
                            wait_cnt_d = WAIT_INIT;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_ERR1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 3'd0) begin
                    state_d = ST_DATA;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state with synchronous reset; a reset mid-transfer simply drops it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Loader write port; memory contents survive reset
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem_q[ld_addr] <= ld_wdata;
        end
    end

    // Synchronous fetch read, sees the pre-write contents when the loader hits the same word
    always_ff @(posedge clk) begin
        if (start_read) begin
            rdata_q <= mem_q[fetch_idx];
        end
    end

    assign ahb.hreadyout = (state_q == ST_IDLE) | (state_q == ST_DATA) | (state_q == ST_ERR2);
    assign ahb.hresp     = (state_q == ST_ERR1) | (state_q == ST_ERR2);
    assign ahb.hrdata    = (state_q == ST_DATA) ? rdata_q : '0;

endmodule

// File: tb/tb_scr1_ahb_imem_slave.sv
// Directed bench for scr1_ahb_imem_slave: three instances with 0, 1 and 3 wait
// states share one stimulus set; hsel and bus hready follow the instance under test.
module tb_scr1_ahb_imem_slave;

    localparam int W     = 32;
    localparam int WORDS = 1024;
    localparam int IDXW  = $clog2(WORDS);

    logic            clk = 1'b0;
    logic            rst;
    logic            hsel;
    logic [1:0]      htrans;
    logic [W-1:0]    haddr;
    logic            hwrite;
    logic [2:0]      hsize;
    logic            ldWe;
    logic [IDXW-1:0] ldAddr;
    logic [W-1:0]    ldWdata;
    int              sel;

    int checkCount = 0;
    int passCount  = 0;

    logic         hreadyBus;
    logic         hrespSel;
    logic [W-1:0] hrdataSel;

    scr1_ahb_imem_slave_if #(.SCR1_AHB_WIDTH(W)) if0 ();
    scr1_ahb_imem_slave_if #(.SCR1_AHB_WIDTH(W)) if1 ();
    scr1_ahb_imem_slave_if #(.SCR1_AHB_WIDTH(W)) if3 ();

    // Shared master-side drive of the three bus bundles
    assign if0.hsel = hsel && (sel == 0);
    assign if1.hsel = hsel && (sel == 1);
    assign if3.hsel = hsel && (sel == 3);
    assign {if0.htrans, if1.htrans, if3.htrans} = {3{htrans}};
    assign {if0.haddr,  if1.haddr,  if3.haddr}  = {3{haddr}};
    assign {if0.hwrite, if1.hwrite, if3.hwrite} = {3{hwrite}};
    assign {if0.hsize,  if1.hsize,  if3.hsize}  = {3{hsize}};
    assign {if0.hburst, if1.hburst, if3.hburst} = {3{3'b000}};
    assign {if0.hprot,  if1.hprot,  if3.hprot}  = {3{4'b0011}};
    assign {if0.hmastlock, if1.hmastlock, if3.hmastlock} = 3'b000;
    assign {if0.hready, if1.hready, if3.hready} = {3{hreadyBus}};

    assign hreadyBus = (sel == 0) ? if0.hreadyout : (sel == 1) ? if1.hreadyout : if3.hreadyout;
    assign hrespSel  = (sel == 0) ? if0.hresp     : (sel == 1) ? if1.hresp     : if3.hresp;
    assign hrdataSel = (sel == 0) ? if0.hrdata    : (sel == 1) ? if1.hrdata    : if3.hrdata;

    scr1_ahb_imem_slave #(.SCR1_AHB_WIDTH(W), .MEM_WORDS(WORDS), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .ahb(if0.slave), .ld_we(ldWe), .ld_addr(ldAddr), .ld_wdata(ldWdata));
    scr1_ahb_imem_slave #(.SCR1_AHB_WIDTH(W), .MEM_WORDS(WORDS), .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst(rst), .ahb(if1.slave), .ld_we(ldWe), .ld_addr(ldAddr), .ld_wdata(ldWdata));
    scr1_ahb_imem_slave #(.SCR1_AHB_WIDTH(W), .MEM_WORDS(WORDS), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .ahb(if3.slave), .ld_we(ldWe), .ld_addr(ldAddr), .ld_wdata(ldWdata));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [1:0] t, input logic [W-1:0] a,
                                 input logic wr, input logic [2:0] sz);
        hsel = s; htrans = t; haddr = a; hwrite = wr; hsize = sz;
    endtask

    task automatic busIdle();
        applyStimulus(1'b0, 2'b00, '0, 1'b0, 3'b010);
    endtask

    task automatic loadWord(input logic [IDXW-1:0] idx, input logic [W-1:0] data);
        ldWe = 1'b1; ldAddr = idx; ldWdata = data;
        nextCycle();
        ldWe = 1'b0;
    endtask

    task automatic checkBus(input string tag, input logic rdy, input logic rsp, input logic [W-1:0] dat);
        checkOutput({tag, ".hreadyout"}, {31'b0, hreadyBus}, {31'b0, rdy});
        checkOutput({tag, ".hresp"},     {31'b0, hrespSel},  {31'b0, rsp});
        checkOutput({tag, ".hrdata"},    hrdataSel,          dat);
    endtask

    // Drives one errored access on the WAIT_STATES=1 instance and checks both error cycles
    task automatic errorAccess(input string tag, input logic [W-1:0] a, input logic wr);
        applyStimulus(1'b1, 2'b10, a, wr, 3'b010);
        nextCycle();
        busIdle();
        checkBus({tag, ".err1"}, 1'b0, 1'b1, '0);
        nextCycle();
        checkBus({tag, ".err2"}, 1'b1, 1'b1, '0);
        nextCycle();
        checkBus({tag, ".idle"}, 1'b1, 1'b0, '0);
    endtask

    // Single fetch on the currently selected instance, waiting a bounded number of cycles
    task automatic fetchWord(input string tag, input logic [W-1:0] a, input int expWaits,
                             input logic [W-1:0] expData);
        int waits;
        applyStimulus(1'b1, 2'b10, a, 1'b0, 3'b010);
        nextCycle();
        busIdle();
        ldWe = 1'b0;
        waits = 0;
        while (hreadyBus == 1'b0 && waits < 12) begin
            waits++;
            nextCycle();
        end
        checkOutput({tag, ".waits"}, W'(waits), W'(expWaits));
        checkBus({tag, ".data"}, 1'b1, 1'b0, expData);
        nextCycle();
    endtask

    initial begin
        sel = 1;
        rst = 1'b1;
        ldWe = 1'b0; ldAddr = '0; ldWdata = '0;
        busIdle();

        // Reset held two cycles, all instances idle
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            checkOutput("rst.ws0.hreadyout", {31'b0, if0.hreadyout}, 32'd1);
            checkOutput("rst.ws3.hresp",     {31'b0, if3.hresp},     32'd0);
            checkBus("rst.ws1", 1'b1, 1'b0, '0);
        end
        rst = 1'b0;
        nextCycle();
        checkBus("idle", 1'b1, 1'b0, '0);

        // BUSY with hsel set is never accepted
        applyStimulus(1'b1, 2'b01, 32'h10, 1'b0, 3'b010);
        nextCycle();
        checkBus("busy", 1'b1, 1'b0, '0);
        busIdle();

        // Single read, one wait state
        loadWord(10'd4, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 2'b10, 32'h10, 1'b0, 3'b010);
        nextCycle();
        busIdle();
        checkBus("ws1.wait", 1'b0, 1'b0, '0);
        nextCycle();
        checkBus("ws1.data", 1'b1, 1'b0, 32'hDEAD_BEEF);
        nextCycle();
        checkBus("ws1.after", 1'b1, 1'b0, '0);

        // Back-to-back NONSEQ reads, zero wait states
        loadWord(10'd0, 32'd1);
        loadWord(10'd1, 32'd2);
        loadWord(10'd2, 32'd3);
        sel = 0;
        applyStimulus(1'b1, 2'b10, 32'h0, 1'b0, 3'b010);
        nextCycle();
        checkBus("b2b.0", 1'b1, 1'b0, 32'd1);
        applyStimulus(1'b1, 2'b10, 32'h4, 1'b0, 3'b010);
        nextCycle();
        checkBus("b2b.1", 1'b1, 1'b0, 32'd2);
        applyStimulus(1'b1, 2'b10, 32'h8, 1'b0, 3'b010);
        nextCycle();
        checkBus("b2b.2", 1'b1, 1'b0, 32'd3);
        busIdle();
        nextCycle();
        checkBus("b2b.idle", 1'b1, 1'b0, '0);

        // Error responses, memory must stay untouched
        sel = 1;
        errorAccess("err.write", 32'h0, 1'b1);
        errorAccess("err.misalign", 32'h2, 1'b0);
        errorAccess("err.range", 32'h0000_1000, 1'b0);
        applyStimulus(1'b1, 2'b10, 32'h4, 1'b0, 3'b000);
        nextCycle();
        busIdle();
        checkBus("err.byte", 1'b0, 1'b1, '0);
        nextCycle();
        nextCycle();
        fetchWord("err.memkept", 32'h0, 1, 32'd1);

        // Loader colliding with a fetch of the same word is read-first
        loadWord(10'd0, 32'hA);
        ldWe = 1'b1; ldAddr = 10'd0; ldWdata = 32'hB;
        fetchWord("coll.old", 32'h0, 1, 32'hA);
        fetchWord("coll.new", 32'h0, 1, 32'hB);

        // Three wait states: latency, then reset dropping a transfer in WAIT
        sel = 3;
        fetchWord("ws3.read", 32'h10, 3, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 2'b10, 32'h10, 1'b0, 3'b010);
        nextCycle();
        busIdle();
        checkBus("ws3.wait", 1'b0, 1'b0, '0);
        nextCycle();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        checkBus("rstmid", 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            checkBus("rstmid.nodata", 1'b1, 1'b0, '0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
